ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xFF reset, 0xF4 enable data reporting) from the FPGA to an attached PS/2 mouse or keyboard using the standard host-request-to-send sequence. It is the transmit counterpart of `ps2_mouse_driver`, which only receives device packets. The block drives the PS/2 clock and data lines as open-drain enables; the top level ties the pad to `1'bz` unless the enable is high. The top level arbitrates line ownership with the receiver.

## Interface
- `INHIBIT_CYCLES`, 12000: `clk` cycles `ps2_clk` is held low before the request (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000: maximum `clk` cycles between consecutive device events before abort (20 ms at 100 MHz).
- `clk`  input  1  system clock, 100 MHz.
- `reset`  input  1  synchronous, active-high reset.
- `tx_start`  input  1  single-cycle request; accepted only when `busy`=0.
- `tx_data`  input  8  byte to send; captured in the cycle `tx_start` is accepted.
- `ps2_clk_in`  input  1  raw PS/2 clock pad value (asynchronous).
- `ps2_data_in`  input  1  raw PS/2 data pad value (asynchronous).
- `ps2_clk_oe`  output  1  1 = pull PS/2 clock low.
- `ps2_data_oe`  output  1  1 = pull PS/2 data low.
- `busy`  output  1  transfer in progress.
- `done`  output  1  one-cycle pulse: byte sent, device acknowledged, lines idle.
- `error`  output  1  one-cycle pulse: timeout or NACK; lines released.

## Operation
- `ps2_clk_in` and `ps2_data_in` pass through a 2-flop synchronizer. A falling edge is the registered synchronized clock transitioning 1→0.
- Frame: start(0), D0..D7 LSB first, odd parity (`~^tx_data`), stop(1), device ACK(0).
- Data-line drive: `ps2_data_oe` = 1 for a 0 bit, 0 for a 1 bit. The stop bit always releases.
- FSM states:
  - IDLE: lines released. On `tx_start`, latch `{parity, tx_data}` and go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles, then go to REQ.
  - REQ: `ps2_data_oe`=1 (start bit) for one cycle with the clock still held, then release `ps2_clk_oe` and go to SHIFT.
  - SHIFT: on falling edges 1..8, drive D0..D7. On edge 9, drive parity. On edge 10, release data (stop). Then go to ACK.
  - ACK: on edge 11, sample synchronized data. 0 goes to WAIT_IDLE. 1 is a NACK and goes to ERR.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then go to DONE.
  - DONE: pulse `done`, go to IDLE.
  - ERR: release both lines, pulse `error`, go to IDLE.
- Timeout counter: cleared on entry to SHIFT and on every falling edge. If it reaches `TIMEOUT_CYCLES` in SHIFT, ACK or WAIT_IDLE, go to ERR.
- `tx_start` while `busy`=1 is ignored; `tx_data` is not re-latched.
- Edge counter is 4 bits and is cleared on entry to SHIFT.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `error`=0; FSM in IDLE; counters at 0.
- Reset asserted mid-transfer releases both lines on the next `clk` edge. No `done` or `error` pulse is generated.
- `tx_start` accepted at edge N:
  - `busy`=1 and `ps2_clk_oe`=1 from edge N+1.
  - `ps2_data_oe`=1 at edge N+1+`INHIBIT_CYCLES`.
  - `ps2_clk_oe`=0 one cycle later.
- A pad falling edge updates `ps2_data_oe` 4 `clk` cycles later (2 sync stages, edge register, output register). This is well inside the ≥5 µs PS/2 clock-low phase.
- `done`/`error` is high for exactly one cycle. `busy` falls in the same cycle the pulse is asserted; a new `tx_start` is accepted on the following cycle.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: the ACK-state sample is enforced; data=1 at edge 11 produces `error`.
- `PS2_TX_ACK_CHECK_EN` undefined: the ACK-state sample is ignored. After edge 11 the FSM always proceeds to WAIT_IDLE and reports `done`. Timeouts still produce `error`.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 kHz and acking low:
  - Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - `done` pulses once; `error` stays 0.
- Send 0x00:
  - Parity bit sampled as 1.
  - `ps2_clk_oe` high for exactly 12000 cycles before the start bit.
- Device never clocks:
  - `error` pulses `TIMEOUT_CYCLES` cycles after clock release.
  - Both OEs are 0 afterwards.
- Device holds data high at edge 11:
  - `error` pulses with `PS2_TX_ACK_CHECK_EN` defined.
  - `done` pulses with it undefined.
- Assert `reset` after edge 5:
  - OEs and `busy` are 0 next cycle; no `done` or `error`.
  - A fresh 0xFF transfer afterwards completes correctly.
- `tx_start` with 0xAA while sending 0xF4:
  - Ignored; device still receives 0xF4.
  - A single `done`.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device using the host request-to-send
// sequence: inhibit the clock, assert the start bit, release the clock, and
// shift D0..D7, odd parity and stop on device clock falling edges. The ACK
// is sampled on falling edge 11.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tx_start, tx_data       one-cycle send request and byte (ignored while busy)
//   ps2_clk_in, ps2_data_in raw pad values (asynchronous)
//   ps2_clk_oe, ps2_data_oe open-drain enables (1 = pull line low)
//   busy                    transfer in progress
//   done, error             one-cycle completion / failure pulses
//
// Build option:
//   PS2_TX_ACK_CHECK_EN     when defined, data=1 at edge 11 (NACK) gives error;
//                           when undefined, the ACK sample is ignored.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [8:0]    shreg;      // {parity, data}, shifted out LSB first
  logic [3:0]    edge_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;

  // Synchronizers; reset to 1 (idle line) so no false edge follows reset.
  logic clk_s1, clk_s2, clk_q, clk_q_d;
  logic data_s1, data_s2;
  logic clk_fall;
  logic timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_q   <= 1'b1;
      clk_q_d <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_q   <= clk_s2;
      clk_q_d <= clk_q;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  assign clk_fall    = clk_q_d & ~clk_q;
  // A falling edge restarts the timeout window, so it never aborts on that cycle.
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !clk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      edge_cnt    <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        // DONE/ERR end their pulse and accept a new request like IDLE, so a
        // request in the cycle after the pulse is never lost.
        S_IDLE, S_DONE, S_ERR: begin
          done        <= 1'b0;
          error       <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= S_IDLE;
          if (tx_start) begin
            shreg      <= {~^tx_data, tx_data};
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;  // start bit while the clock is still held
            state       <= S_REQ;
          end
        end

        S_REQ: begin
          ps2_clk_oe <= 1'b0;
          edge_cnt   <= '0;
          to_cnt     <= '0;
          state      <= S_SHIFT;
        end

        S_SHIFT, S_ACK, S_WAIT_IDLE: begin
          to_cnt <= clk_fall ? '0 : to_cnt + 1'b1;
          if (timeout_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            state       <= S_ERR;
          end else if (state == S_SHIFT) begin
            if (clk_fall) begin
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt == 4'd9) begin
                ps2_data_oe <= 1'b0;  // stop bit: release
                state       <= S_ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
              end
            end
          end else if (state == S_ACK) begin
            if (clk_fall) begin
              edge_cnt <= edge_cnt + 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
              if (data_s2) begin
                busy  <= 1'b0;
                error <= 1'b1;
                state <= S_ERR;
              end else begin
                state <= S_WAIT_IDLE;
              end
`else
              state <= S_WAIT_IDLE;
`endif
            end
          end else begin
            if (clk_q && data_s2) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
